// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the main-memory line port arbiter.
package mem_arb_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 26;

    // Transaction sequencing: one line transaction in flight at a time.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    // Which requester owns the current transaction.
    typedef enum logic [1:0] {
        GNT_I   = 2'd0,
        GNT_DRD = 2'd1,
        GNT_DWR = 2'd2
    } arb_gnt_t;

    // Only the D-cache writeback drives a write onto the backend.
    function automatic logic gnt_is_write(input arb_gnt_t gnt);
        return (gnt == GNT_DWR);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_priority_sel.sv
// Combinational winner pick among the three line-port requesters.
// Writeback always wins so dirty lines leave before a refill can reuse the
// set; D reads beat I fetches unless the I side has been starved too long.
module arb_priority_sel
    import mem_arb_pkg::*;
(
    input  logic     req_i,
    input  logic     req_d_rd,
    input  logic     req_d_wr,
    input  logic     starve_hit,
    output arb_gnt_t gnt,
    output logic     valid
);

    // Fixed priority with a starvation override for the I-cache over D reads.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt   = GNT_I;
        valid = req_i | req_d_rd | req_d_wr;
        if (req_d_wr) begin
            gnt = GNT_DWR;
        end else if (req_d_rd && !(starve_hit && req_i)) begin
            gnt = GNT_DRD;
        end else begin
            gnt = GNT_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory line port between I-cache fill, D-cache fill
// and D-cache writeback. One line transaction at a time: the winner is latched
// in IDLE, presented to the backend in ISSUE, and acknowledged with a one-cycle
// pulse in RESP. RESP always returns through IDLE so a requester dropping its
// request after the pulse is never re-granted on a stale level.
module mem_port_arbiter #(
    parameter int LINE_W     = mem_arb_pkg::LINE_W,
    parameter int ADDR_W     = mem_arb_pkg::ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqI,
    input  logic [ADDR_W-1:0] addrI,
    input  logic              reqD_rd,
    input  logic [ADDR_W-1:0] addrD_rd,
    input  logic              reqD_wr,
    input  logic [ADDR_W-1:0] addrD_wr,
    input  logic [LINE_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [LINE_W-1:0] rdata,
    output logic              i_ready,
    output logic              d_ready,
    output logic              wr_ack
);

    import mem_arb_pkg::*;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t        state_q, state_d;
    arb_gnt_t          gnt_q, gnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              wr_ack_q, wr_ack_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    arb_gnt_t          sel_gnt;
    logic              sel_valid;
    logic              starve_hit;

    assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_MAX));

    arb_priority_sel u_sel (
        .req_i      (reqI),
        .req_d_rd   (reqD_rd),
        .req_d_wr   (reqD_wr),
        .starve_hit (starve_hit),
        .gnt        (sel_gnt),
        .valid      (sel_valid)
    );

    // Next-state and next-output logic for the IDLE -> ISSUE -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        starve_cnt_d = starve_cnt_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        wr_ack_d     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (sel_valid) begin
                    gnt_d     = sel_gnt;
                    mem_req_d = 1'b1;
                    mem_we_d  = gnt_is_write(sel_gnt);
                    state_d   = ARB_ISSUE;
                    case (sel_gnt)
                        GNT_DWR: begin
                            addr_d  = addrD_wr;
                            wdata_d = wdata;
                        end
                        GNT_DRD: addr_d = addrD_rd;
                        default: addr_d = addrI;
                    endcase
                end
                // Count rounds the I-cache asked for but lost; saturate at the limit.
                if (reqI) begin
                    if (sel_gnt == GNT_I) begin
                        starve_cnt_d = '0;
                    end else if (!starve_hit) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end

            ARB_ISSUE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ARB_RESP;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    case (gnt_q)
                        GNT_DWR: wr_ack_d  = 1'b1;
                        GNT_DRD: d_ready_d = 1'b1;
                        default: i_ready_d = 1'b1;
                    endcase
                end
            end

            ARB_RESP: begin
                state_d = ARB_IDLE;
            end

            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State, latched transaction and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: rdata is a datapath register but is still reset; caches expect a clean 0 line after reset.
        if (!reset) begin
            state_q      <= ARB_IDLE;
            gnt_q        <= GNT_I;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            wr_ack_q     <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            wr_ack_q     <= wr_ack_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign wr_ack    = wr_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single arbitration rounds
// followed by hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

    localparam int LW = 128;
    localparam int AW = 26;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqI, reqD_rd, reqD_wr;
    logic [AW-1:0] addrI, addrD_rd, addrD_wr;
    logic [LW-1:0] wdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_ack;
    logic [LW-1:0] mem_rdata;
    logic [LW-1:0] rdata;
    logic          i_ready, d_ready, wr_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LINE_W(LW), .ADDR_W(AW), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .reqI      (reqI),
        .addrI     (addrI),
        .reqD_rd   (reqD_rd),
        .addrD_rd  (addrD_rd),
        .reqD_wr   (reqD_wr),
        .addrD_wr  (addrD_wr),
        .wdata     (wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rdata     (rdata),
        .i_ready   (i_ready),
        .d_ready   (d_ready),
        .wr_ack    (wr_ack)
    );

    // One arbitration round: requests {I, D rd, D wr} and the expected result.
    typedef struct {
        logic [2:0]    req;
        logic [AW-1:0] a_i;
        logic [AW-1:0] a_rd;
        logic [AW-1:0] a_wr;
        logic [LW-1:0] wd;
        int            delay;
        logic [LW-1:0] ack_data;
        logic [2:0]    exp_pulse;   // {i_ready, d_ready, wr_ack}
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction with requests already driven and the DUT in IDLE.
    // Returns one cycle after the pulse, with the DUT back in IDLE.
    task automatic do_txn(input string name, input logic [2:0] exp_pulse,
                          input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_wdata,
                          input int delay, input logic [LW-1:0] ack_data,
                          input logic [LW-1:0] exp_rdata, input bit drop);
        step();
        check($sformatf("%s_req", name), mem_req, 1);
        check($sformatf("%s_we", name), mem_we, exp_pulse[0]);
        check($sformatf("%s_addr", name), mem_addr, exp_addr);
        if (exp_pulse[0]) check($sformatf("%s_wdata", name), mem_wdata, exp_wdata);
        for (int i = 0; i < delay; i++) begin
            step();
            check($sformatf("%s_req_hold", name), mem_req, 1);
        end
        mem_ack   = 1'b1;
        mem_rdata = ack_data;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check($sformatf("%s_pulse", name), {i_ready, d_ready, wr_ack}, exp_pulse);
        check($sformatf("%s_rdata", name), rdata, exp_rdata);
        check($sformatf("%s_req_drop", name), mem_req, 0);
        step();
        check($sformatf("%s_pulse_end", name), {i_ready, d_ready, wr_ack}, 3'b000);
        if (drop) begin
            if (exp_pulse[2]) reqI = 1'b0;
            if (exp_pulse[1]) reqD_rd = 1'b0;
            if (exp_pulse[0]) reqD_wr = 1'b0;
        end
    endtask

    initial begin
        logic [LW-1:0] last_rd;

        vecs[0] = '{3'b100, 26'h40, 26'h0, 26'h0, '0, 2, {16{8'hA5}},
                    3'b100, 26'h40, {16{8'hA5}}};
        vecs[1] = '{3'b010, 26'h0, 26'h123, 26'h0, '0, 0, {4{32'h1111_2222}},
                    3'b010, 26'h123, {4{32'h1111_2222}}};
        vecs[2] = '{3'b001, 26'h0, 26'h0, 26'h3FF_FFFF, {4{32'hDEAD_BEEF}}, 1, {LW{1'b1}},
                    3'b001, 26'h3FF_FFFF, {4{32'h1111_2222}}};
        vecs[3] = '{3'b111, 26'h1, 26'h2, 26'h3, {4{32'hCAFE_F00D}}, 0, {LW{1'b1}},
                    3'b001, 26'h3, {4{32'h1111_2222}}};
        vecs[4] = '{3'b110, 26'h4, 26'h5, 26'h0, '0, 1, {4{32'h0F0F_0F0F}},
                    3'b010, 26'h5, {4{32'h0F0F_0F0F}}};
        vecs[5] = '{3'b100, 26'h6, 26'h0, 26'h0, '0, 0, {4{32'h7777_8888}},
                    3'b100, 26'h6, {4{32'h7777_8888}}};

        reset = 1'b0;
        {reqI, reqD_rd, reqD_wr} = 3'b000;
        addrI = '0; addrD_rd = '0; addrD_wr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) step();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_pulses", {i_ready, d_ready, wr_ack}, 3'b000);
        reset = 1'b1;
        step();
        check("idle_no_req", mem_req, 0);

        // Table of single rounds; all requests dropped after each.
        for (int v = 0; v < 6; v++) begin
            {reqI, reqD_rd, reqD_wr} = vecs[v].req;
            addrI = vecs[v].a_i; addrD_rd = vecs[v].a_rd; addrD_wr = vecs[v].a_wr;
            wdata = vecs[v].wd;
            do_txn($sformatf("vec%0d", v), vecs[v].exp_pulse, vecs[v].exp_addr, vecs[v].wd,
                   vecs[v].delay, vecs[v].ack_data, vecs[v].exp_rdata, 1'b0);
            {reqI, reqD_rd, reqD_wr} = 3'b000;
        end

        // Starvation: D read and I held together; I must win the 5th round.
        reqI = 1'b1; addrI = 26'h0AA;
        reqD_rd = 1'b1; addrD_rd = 26'h0BB;
        for (int r = 0; r < 4; r++)
            do_txn($sformatf("starve_d%0d", r), 3'b010, 26'h0BB, '0, 0,
                   {4{r[31:0] + 32'h10}}, {4{r[31:0] + 32'h10}}, 1'b0);
        do_txn("starve_i", 3'b100, 26'h0AA, '0, 0, {4{32'h5A5A_0001}}, {4{32'h5A5A_0001}}, 1'b0);
        // Counter cleared by the I grant, so D wins again straight away.
        do_txn("starve_clr", 3'b010, 26'h0BB, '0, 0, {4{32'h5A5A_0002}}, {4{32'h5A5A_0002}}, 1'b0);
        {reqI, reqD_rd, reqD_wr} = 3'b000;
        step();

        // Three-way collision held: wr, then D read, then I.
        reqI = 1'b1; addrI = 26'h111;
        reqD_rd = 1'b1; addrD_rd = 26'h222;
        reqD_wr = 1'b1; addrD_wr = 26'h333; wdata = {4{32'h0123_4567}};
        do_txn("ord_wr", 3'b001, 26'h333, {4{32'h0123_4567}}, 1, {LW{1'b1}}, {4{32'h5A5A_0002}}, 1'b1);
        do_txn("ord_rd", 3'b010, 26'h222, '0, 0, {4{32'hAAAA_0002}}, {4{32'hAAAA_0002}}, 1'b1);
        do_txn("ord_i", 3'b100, 26'h111, '0, 2, {4{32'hAAAA_0003}}, {4{32'hAAAA_0003}}, 1'b1);
        check("ord_all_dropped", {reqI, reqD_rd, reqD_wr}, 3'b000);

        // Writeback then read of the same top line address.
        reqD_wr = 1'b1; addrD_wr = 26'h3FF_FFFF; wdata = {4{32'hFEED_FACE}};
        reqD_rd = 1'b1; addrD_rd = 26'h3FF_FFFF;
        do_txn("wbrd_wr", 3'b001, 26'h3FF_FFFF, {4{32'hFEED_FACE}}, 0, {LW{1'b1}},
               {4{32'hAAAA_0003}}, 1'b1);
        do_txn("wbrd_rd", 3'b010, 26'h3FF_FFFF, '0, 0, {4{32'hFEED_FACE}}, {4{32'hFEED_FACE}}, 1'b1);

        // Address change during ISSUE must not reach the backend.
        reqI = 1'b1; addrI = 26'h055;
        step();
        check("hold_addr0", mem_addr, 26'h055);
        addrI = 26'h099;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_addr%0d", i + 1), mem_addr, 26'h055);
            check($sformatf("hold_req%0d", i + 1), mem_req, 1);
        end
        last_rd = {4{32'h9999_0055}};
        mem_ack = 1'b1; mem_rdata = last_rd;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        check("hold_pulse", {i_ready, d_ready, wr_ack}, 3'b100);
        check("hold_rdata", rdata, last_rd);
        step();
        reqI = 1'b0;
        step();

        // Stray ack in IDLE is ignored.
        mem_ack = 1'b1; mem_rdata = {LW{1'b1}};
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        check("idle_ack_pulse", {i_ready, d_ready, wr_ack}, 3'b000);
        check("idle_ack_rdata", rdata, last_rd);
        check("idle_ack_req", mem_req, 0);

        // Reset during ISSUE, late ack arrives afterwards.
        reqI = 1'b1; addrI = 26'h077;
        step();
        check("mid_rst_issue", mem_req, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        reqI = 1'b0;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_rdata", rdata, 0);
        mem_ack = 1'b1; mem_rdata = {4{32'hBEEF_BEEF}};
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        check("late_ack_pulse", {i_ready, d_ready, wr_ack}, 3'b000);
        check("late_ack_req", mem_req, 0);
        check("late_ack_rdata", rdata, 0);
        step();
        check("late_ack_pulse2", {i_ready, d_ready, wr_ack}, 3'b000);

        // Fresh transaction after reset starts from IDLE.
        reqD_rd = 1'b1; addrD_rd = 26'h010;
        do_txn("post_rst", 3'b010, 26'h010, '0, 0, {4{32'h0000_C0DE}}, {4{32'h0000_C0DE}}, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
